// File: rtl/tour_sequencer.sv
// rtl/tour_sequencer.sv - knight's-tour replay sequencer between the solver and the command processor
//
// Purpose:
//   Launches the tour solver, waits for it to finish (with a timeout), then
//   replays moves 0..NUM_MOVES-1. Each one-hot move becomes a vertical
//   command followed by a horizontal command. Each command goes to the
//   command processor through a valid/ack/response handshake.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start        one-cycle tour request, honoured in IDLE/DONE/ERR only
//   x_start      start column for the solver
//   y_start      start row for the solver
//   tour_go      one-cycle solver launch pulse
//   tour_done    solver finished, sampled only while solving
//   indx         move index presented to the solver
//   move         one-hot move at indx (combinational from indx)
//   cmd          command word, stable while cmd_vld=1
//   cmd_vld      command valid
//   cmd_ack      consumer accepted cmd
//   resp_done    consumer finished the accepted cmd
//   busy         sequencer active (not IDLE/DONE/ERR)
//   tour_cmplt   all moves replayed
//   err_timeout  sticky: solver never reported done
//   err_move     sticky: move was not exactly one-hot
module tour_sequencer #(
  parameter int NUM_MOVES = 24,
  parameter int TIMEOUT   = 8000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  x_start,
  input  logic [2:0]  y_start,
  output logic        tour_go,
  input  logic        tour_done,
  output logic [4:0]  indx,
  input  logic [7:0]  move,
  output logic [15:0] cmd,
  output logic        cmd_vld,
  input  logic        cmd_ack,
  input  logic        resp_done,
  output logic        busy,
  output logic        tour_cmplt,
  output logic        err_timeout,
  output logic        err_move
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;
  localparam logic [7:0] HDG_N      = 8'h00;
  localparam logic [7:0] HDG_W      = 8'h3F;
  localparam logic [7:0] HDG_S      = 8'h7F;
  localparam logic [7:0] HDG_E      = 8'hBF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SOLVE,
    S_VI,
    S_VA,
    S_VR,
    S_HI,
    S_HA,
    S_HR,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state, state_n;
  logic            go_n;
  logic [4:0]      indx_n;
  logic [15:0]     cmd_n;
  logic            vld_n;
  logic [15:0]     hcmd, hcmd_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            err_timeout_n, err_move_n;

  logic            mv_ok;
  logic [15:0]     mv_vert, mv_horz;

  // The start square goes straight to the solver alongside tour_go; this
  // block only forwards the launch pulse.
  logic unused_start_sq;
  assign unused_start_sq = ^{x_start, y_start};

  // Move decode. Any pattern that is not a single set bit lands in default
  // and is reported as a bad move.
  always_comb begin
    mv_ok   = 1'b1;
    mv_vert = 16'h0000;
    mv_horz = 16'h0000;
    case (move)
      8'h01: begin mv_vert = {OP_MOVE, HDG_N, 4'd2}; mv_horz = {OP_FANFARE, HDG_E, 4'd1}; end
      8'h02: begin mv_vert = {OP_MOVE, HDG_N, 4'd2}; mv_horz = {OP_FANFARE, HDG_W, 4'd1}; end
      8'h04: begin mv_vert = {OP_MOVE, HDG_N, 4'd1}; mv_horz = {OP_FANFARE, HDG_W, 4'd2}; end
      8'h08: begin mv_vert = {OP_MOVE, HDG_S, 4'd1}; mv_horz = {OP_FANFARE, HDG_W, 4'd2}; end
      8'h10: begin mv_vert = {OP_MOVE, HDG_S, 4'd2}; mv_horz = {OP_FANFARE, HDG_W, 4'd1}; end
      8'h20: begin mv_vert = {OP_MOVE, HDG_S, 4'd2}; mv_horz = {OP_FANFARE, HDG_E, 4'd1}; end
      8'h40: begin mv_vert = {OP_MOVE, HDG_S, 4'd1}; mv_horz = {OP_FANFARE, HDG_E, 4'd2}; end
      8'h80: begin mv_vert = {OP_MOVE, HDG_N, 4'd1}; mv_horz = {OP_FANFARE, HDG_E, 4'd2}; end
      default: mv_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_n       = state;
    go_n          = 1'b0;
    indx_n        = indx;
    cmd_n         = cmd;
    vld_n         = cmd_vld;
    hcmd_n        = hcmd;
    cnt_n         = cnt;
    err_timeout_n = err_timeout;
    err_move_n    = err_move;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_SOLVE;
          go_n    = 1'b1;
          cnt_n   = '0;
        end
      end
      S_SOLVE: begin
        // A done seen on the last allowed cycle still wins over the timeout.
        if (tour_done) begin
          indx_n  = 5'd0;
          state_n = S_VI;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_timeout_n = 1'b1;
          state_n       = S_ERR;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_VI: begin
        if (!mv_ok) begin
          err_move_n = 1'b1;
          vld_n      = 1'b0;
          state_n    = S_ERR;
        end else begin
          // The horizontal half is captured now so the second command does
          // not depend on the solver still driving the same move later.
          cmd_n   = mv_vert;
          hcmd_n  = mv_horz;
          vld_n   = 1'b1;
          state_n = S_VA;
        end
      end
      S_VA: begin
        if (cmd_ack) begin
          vld_n   = 1'b0;
          state_n = S_VR;
        end
      end
      S_VR: begin
        if (resp_done) state_n = S_HI;
      end
      S_HI: begin
        cmd_n   = hcmd;
        vld_n   = 1'b1;
        state_n = S_HA;
      end
      S_HA: begin
        if (cmd_ack) begin
          vld_n   = 1'b0;
          state_n = S_HR;
        end
      end
      S_HR: begin
        if (resp_done) state_n = S_NEXT;
      end
      S_NEXT: begin
        if (indx == 5'(NUM_MOVES - 1)) begin
          state_n = S_DONE;
        end else begin
          indx_n  = indx + 5'd1;
          state_n = S_VI;
        end
      end
      S_DONE: begin
        if (start) begin
          state_n = S_SOLVE;
          go_n    = 1'b1;
          cnt_n   = '0;
        end
      end
      S_ERR: begin
        vld_n = 1'b0;
        if (start) begin
          err_timeout_n = 1'b0;
          err_move_n    = 1'b0;
          state_n       = S_SOLVE;
          go_n          = 1'b1;
          cnt_n         = '0;
        end
      end
      default: begin
        vld_n   = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tour_go     <= 1'b0;
      indx        <= 5'd0;
      cmd         <= 16'h0000;
      cmd_vld     <= 1'b0;
      hcmd        <= 16'h0000;
      cnt         <= '0;
      err_timeout <= 1'b0;
      err_move    <= 1'b0;
    end else begin
      state       <= state_n;
      tour_go     <= go_n;
      indx        <= indx_n;
      cmd         <= cmd_n;
      cmd_vld     <= vld_n;
      hcmd        <= hcmd_n;
      cnt         <= cnt_n;
      err_timeout <= err_timeout_n;
      err_move    <= err_move_n;
    end
  end

  assign busy       = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
  assign tour_cmplt = (state == S_DONE);

endmodule

// File: tb/tb_tour_sequencer.sv
// tb/tb_tour_sequencer.sv - self-checking bench for tour_sequencer
module tb_tour_sequencer;

  localparam int NM   = 24;
  localparam int TOUT = 150;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  x_start, y_start;
  logic        tour_go;
  logic        tour_done;
  logic [4:0]  indx;
  logic [7:0]  move;
  logic [15:0] cmd;
  logic        cmd_vld;
  logic        cmd_ack, resp_done;
  logic        busy, tour_cmplt, err_timeout, err_move;

  logic        c_ack, c_resp, m_ack, m_resp;
  assign cmd_ack   = c_ack | m_ack;
  assign resp_done = c_resp | m_resp;

  logic [7:0]  moves [0:31];
  always_comb move = moves[indx];

  int n_cmp = 0;
  int n_bad = 0;
  int viol = 0;
  int vld_cycles = 0;

  logic        cons_en, rnd_dly;
  int          ack_dly, resp_dly;
  logic [15:0] log_q [$];

  typedef struct packed {
    logic [7:0]  mv;
    logic [15:0] v;
    logic [15:0] h;
  } vec_t;
  vec_t vec [8];

  tour_sequencer #(.NUM_MOVES(NM), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .x_start(x_start), .y_start(y_start),
    .tour_go(tour_go), .tour_done(tour_done), .indx(indx), .move(move),
    .cmd(cmd), .cmd_vld(cmd_vld), .cmd_ack(cmd_ack), .resp_done(resp_done),
    .busy(busy), .tour_cmplt(tour_cmplt), .err_timeout(err_timeout), .err_move(err_move)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: a command offered without ack must still be offered,
  // unchanged, after the edge; indx must never pass the last move.
  logic        p_pend;
  logic [15:0] p_cmd;
  initial p_pend = 1'b0;
  always @(posedge clk) begin
    if (p_pend && !rst && (!cmd_vld || cmd != p_cmd)) viol <= viol + 1;
    if (!rst && indx > 5'(NM - 1)) viol <= viol + 1;
    if (cmd_vld) vld_cycles <= vld_cycles + 1;
    p_pend <= !rst && cmd_vld && !cmd_ack;
    p_cmd  <= cmd;
  end

  // Command processor model: accepts after ack_dly cycles, responds after
  // resp_dly more cycles, and records every accepted command.
  initial begin
    c_ack  = 1'b0;
    c_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (cons_en && cmd_vld && !rst) begin
        int ad, rd;
        ad = rnd_dly ? int'($urandom_range(0, 3)) : ack_dly;
        rd = rnd_dly ? int'($urandom_range(0, 4)) : resp_dly;
        repeat (ad) @(negedge clk);
        c_ack = 1'b1;
        log_q.push_back(cmd);
        @(negedge clk);
        c_ack = 1'b0;
        repeat (rd) @(negedge clk);
        c_resp = 1'b1;
        @(negedge clk);
        c_resp = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Reference decode built from the (dx,dy) move table and heading rules.
  function automatic logic [15:0] model_cmd(input logic [7:0] m, input bit horiz);
    int dxs [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dys [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
    int k, d, mag;
    logic [7:0] hd;
    k = 0;
    for (int i = 0; i < 8; i++) if (m[i]) k = i;
    d   = horiz ? dxs[k] : dys[k];
    mag = (d > 0) ? d : -d;
    if (horiz) begin
      hd = (d > 0) ? 8'hBF : 8'h3F;
      return {4'h3, hd, 4'(mag)};
    end
    hd = (d > 0) ? 8'h00 : 8'h7F;
    return {4'h2, hd, 4'(mag)};
  endfunction

  task automatic launch(input int done_dly);
    x_start = 3'($urandom_range(0, 4));
    y_start = 3'($urandom_range(0, 4));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("tour_go_latency", tour_go, 1);
    repeat (done_dly) @(negedge clk);
    tour_done = 1'b1;
    @(negedge clk);
    tour_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk(name, busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tour_go"}, tour_go, 0);
    chk({tag, "_indx"}, indx, 0);
    chk({tag, "_cmd"}, cmd, 0);
    chk({tag, "_cmd_vld"}, cmd_vld, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tour_cmplt"}, tour_cmplt, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_err_move"}, err_move, 0);
  endtask

  initial begin
    int k, v0;
    rst = 1'b1; start = 1'b0; x_start = 3'd0; y_start = 3'd0; tour_done = 1'b0;
    m_ack = 1'b0; m_resp = 1'b0; cons_en = 1'b0; rnd_dly = 1'b0;
    ack_dly = 0; resp_dly = 0;

    vec[0] = '{8'h01, 16'h2002, 16'h3BF1};
    vec[1] = '{8'h02, 16'h2002, 16'h33F1};
    vec[2] = '{8'h04, 16'h2001, 16'h33F2};
    vec[3] = '{8'h08, 16'h27F1, 16'h33F2};
    vec[4] = '{8'h10, 16'h27F2, 16'h33F1};
    vec[5] = '{8'h20, 16'h27F2, 16'h3BF1};
    vec[6] = '{8'h40, 16'h27F1, 16'h3BF2};
    vec[7] = '{8'h80, 16'h2001, 16'h3BF2};
    for (int i = 0; i < 32; i++) moves[i] = vec[i % 8].mv;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Nominal first move with a slow consumer.
    cons_en = 1'b1; ack_dly = 2; resp_dly = 5;
    log_q.delete();
    launch(100);
    k = 0;
    while (log_q.size() < 3 && k < 2000) begin @(negedge clk); k++; end
    chk("nominal_indx_advance", indx, 1);
    wait_idle("nominal_idle");
    chk("nominal_cmd0", log_q[0], 16'h2002);
    chk("nominal_cmd1", log_q[1], 16'h3BF1);

    // Decode sweep over a full tour with immediate handshakes.
    ack_dly = 0; resp_dly = 0;
    log_q.delete();
    launch(5);
    wait_idle("sweep_idle");
    chk("sweep_handshakes", log_q.size(), 2 * NM);
    chk("sweep_last_indx", indx, NM - 1);
    chk("sweep_tour_cmplt", tour_cmplt, 1);
    chk("sweep_busy", busy, 0);
    chk("sweep_err_flags", {err_timeout, err_move}, 0);
    if (log_q.size() == 2 * NM) begin
      for (int i = 0; i < NM; i++) begin
        chk($sformatf("sweep_v%0d", i), log_q[2 * i], vec[i % 8].v);
        chk($sformatf("sweep_h%0d", i), log_q[2 * i + 1], vec[i % 8].h);
      end
    end

    // Randomized tours against the reference decode.
    rnd_dly = 1'b1;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NM; i++) moves[i] = 8'(1 << $urandom_range(0, 7));
      log_q.delete();
      launch(int'($urandom_range(0, 60)));
      wait_idle($sformatf("rand%0d_idle", t));
      chk($sformatf("rand%0d_handshakes", t), log_q.size(), 2 * NM);
      chk($sformatf("rand%0d_cmplt", t), tour_cmplt, 1);
      if (log_q.size() == 2 * NM) begin
        for (int i = 0; i < NM; i++) begin
          chk($sformatf("rand%0d_v%0d", t, i), log_q[2 * i], model_cmd(moves[i], 1'b0));
          chk($sformatf("rand%0d_h%0d", t, i), log_q[2 * i + 1], model_cmd(moves[i], 1'b1));
        end
      end
    end
    rnd_dly = 1'b0;

    // Solver timeout: tour_go cycle counts as cycle 0.
    v0 = vld_cycles;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("timeout_tour_go", tour_go, 1);
    repeat (TOUT - 1) @(negedge clk);
    chk("timeout_not_yet", err_timeout, 0);
    @(negedge clk);
    chk("timeout_flag", err_timeout, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_no_cmd", vld_cycles - v0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("timeout_clear", err_timeout, 0);
    chk("timeout_restart_go", tour_go, 1);
    tour_done = 1'b1;
    @(negedge clk);
    tour_done = 1'b0;
    wait_idle("timeout_recover_idle");
    chk("timeout_recover_cmplt", tour_cmplt, 1);

    // Zero move at index 3.
    for (int i = 0; i < 32; i++) moves[i] = vec[i % 8].mv;
    moves[3] = 8'h00;
    log_q.delete();
    launch(3);
    wait_idle("badmove_idle");
    chk("badmove_flag", err_move, 1);
    chk("badmove_cmplt", tour_cmplt, 0);
    chk("badmove_vld", cmd_vld, 0);
    chk("badmove_indx", indx, 3);
    chk("badmove_cmds", log_q.size(), 6);

    // Two bits set at index 0; the restart also clears the old flag.
    moves[3] = 8'h08;
    moves[0] = 8'h03;
    log_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("multibit_clear", err_move, 0);
    tour_done = 1'b1;
    @(negedge clk);
    tour_done = 1'b0;
    wait_idle("multibit_idle");
    chk("multibit_flag", err_move, 1);
    chk("multibit_indx", indx, 0);
    chk("multibit_cmds", log_q.size(), 0);

    // Protocol corners, consumer driven by hand.
    cons_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ack = 1'b1; m_resp = 1'b1; tour_done = 1'b1;
    @(negedge clk);
    m_ack = 1'b0; m_resp = 1'b0; tour_done = 1'b0;
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_vld", cmd_vld, 0);
    moves[0] = 8'h40;
    launch(0);
    k = 0;
    while (!cmd_vld && k < 10) begin @(negedge clk); k++; end
    chk("corner_vcmd", cmd, 16'h27F1);
    m_resp = 1'b1; start = 1'b1;
    @(negedge clk);
    m_resp = 1'b0; start = 1'b0;
    chk("early_resp_vld_held", cmd_vld, 1);
    chk("start_busy_no_go", tour_go, 0);
    m_ack = 1'b1; m_resp = 1'b1;
    @(negedge clk);
    m_ack = 1'b0; m_resp = 1'b0;
    chk("ack_drops_vld", cmd_vld, 0);
    repeat (3) @(negedge clk);
    chk("resp_with_ack_ignored", cmd_vld, 0);
    m_resp = 1'b1;
    @(negedge clk);
    m_resp = 1'b0;
    chk("gap_after_resp", cmd_vld, 0);
    @(negedge clk);
    chk("corner_hvld", cmd_vld, 1);
    chk("corner_hcmd", cmd, 16'h3BF2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst_mid_ha");

    chk("handshake_monitor", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
